// File: rtl/collision_scanner.sv
// Sequential collision scanner: tests one snapshotted enemy box per clock against
// the player box on a toroidal screen and reports any-hit, lowest hit index and hit mask.
module collision_scanner #(
   parameter int NUM_ENEMIES = 5,
   parameter int XW          = 8,
   parameter int YW          = 7,
   parameter int SCREEN_W    = 160,
   parameter int SCREEN_H    = 120,
   parameter int ENEMY_W     = 4,
   parameter int ENEMY_H     = 4,
   parameter int PLAYER_W    = 1,
   parameter int PLAYER_H    = 1,
   parameter int IDXW        = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      detectCollide,
   input  logic                      space_pressed,
   input  logic [XW-1:0]             player_x,
   input  logic [YW-1:0]             player_y,
   input  logic [NUM_ENEMIES*XW-1:0] enemy_x,
   input  logic [NUM_ENEMIES*YW-1:0] enemy_y,
   input  logic [NUM_ENEMIES-1:0]    enemy_active,
   output logic                      doneDetect,
   output logic                      collide,
   output logic [IDXW-1:0]           hit_index,
   output logic [NUM_ENEMIES-1:0]    hit_mask
);

   // Common width for both axes; one extra bit holds p + modulus - e without overflow.
   localparam int CW = ((XW > YW) ? XW : YW) + 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_ENEMIES - 1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t                    state;
   logic [IDXW-1:0]           idx;
   logic [XW-1:0]             snap_px;
   logic [YW-1:0]             snap_py;
   logic [NUM_ENEMIES*XW-1:0] snap_ex;
   logic [NUM_ENEMIES*YW-1:0] snap_ey;
   logic [NUM_ENEMIES-1:0]    snap_act;
   logic [NUM_ENEMIES-1:0]    acc_mask;
   logic [IDXW-1:0]           acc_index;

   logic [XW-1:0]             cur_ex;
   logic [YW-1:0]             cur_ey;
   logic                      cur_hit;
   logic [NUM_ENEMIES-1:0]    mask_next;
   logic [IDXW-1:0]           index_next;

   // Wrapped 1-D overlap; out-of-range coordinates never overlap.
   function automatic logic axis_overlap(input logic [CW-1:0] p, input logic [CW-1:0] e,
                                         input int modulus, input int box, input int ply);
      logic [CW-1:0] d;
      logic          in_range;
      in_range = (p < CW'(modulus)) && (e < CW'(modulus));
      d        = (p >= e) ? (p - e) : (p + CW'(modulus) - e);
      return in_range && ((d < CW'(box)) || (d > CW'(modulus - ply)));
   endfunction

   always_comb begin
      cur_ex     = snap_ex[int'(idx)*XW +: XW];
      cur_ey     = snap_ey[int'(idx)*YW +: YW];
      cur_hit    = snap_act[idx]
                   && axis_overlap(CW'(snap_px), CW'(cur_ex), SCREEN_W, ENEMY_W, PLAYER_W)
                   && axis_overlap(CW'(snap_py), CW'(cur_ey), SCREEN_H, ENEMY_H, PLAYER_H);
      mask_next  = acc_mask | (cur_hit ? (NUM_ENEMIES'(1) << idx) : '0);
      // The first hit found wins; scanning is ascending, so that is the lowest index.
      index_next = (cur_hit && (acc_mask == '0)) ? idx : acc_index;
   end

   // NOTE: every register below uses non-blocking assignment so all state updates
   // see pre-edge values; the snapshot registers are reset too so no X reaches the datapath.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         idx        <= '0;
         snap_px    <= '0;
         snap_py    <= '0;
         snap_ex    <= '0;
         snap_ey    <= '0;
         snap_act   <= '0;
         acc_mask   <= '0;
         acc_index  <= '0;
         doneDetect <= 1'b0;
         collide    <= 1'b0;
         hit_index  <= '0;
         hit_mask   <= '0;
      end else if (space_pressed) begin
         state      <= IDLE;
         idx        <= '0;
         acc_mask   <= '0;
         acc_index  <= '0;
         doneDetect <= 1'b0;
         collide    <= 1'b0;
         hit_index  <= '0;
         hit_mask   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (detectCollide) begin
                  snap_px   <= player_x;
                  snap_py   <= player_y;
                  snap_ex   <= enemy_x;
                  snap_ey   <= enemy_y;
                  snap_act  <= enemy_active;
                  acc_mask  <= '0;
                  acc_index <= '0;
                  idx       <= '0;
                  state     <= SCAN;
               end
            end
            SCAN: begin
               if (!detectCollide) begin
                  state <= IDLE;
                  idx   <= '0;
               end else begin
                  acc_mask  <= mask_next;
                  acc_index <= index_next;
                  if (idx == LAST_IDX) begin
                     hit_mask   <= mask_next;
                     collide    <= |mask_next;
                     hit_index  <= index_next;
                     doneDetect <= 1'b1;
                     idx        <= '0;
                     state      <= DONE;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            DONE: begin
               if (!detectCollide) begin
                  doneDetect <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
